fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end. It keeps at most one memory request in flight and
// feeds a single-entry buffer that drives the IF/ID register directly.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instrOut,
  output logic [31:0] PCplus4,
  output logic        hold,
  output logic        IF_flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pcplus4_q, buf_pcplus4_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        consume;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_word(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign pc_plus4    = next_word(pc_q);
  assign redirect_pc = word_align(branch_target);
  assign instrOut    = buf_instr_q;
  assign PCplus4     = buf_pcplus4_q;

  // With nothing in the buffer the ID stage gets a bubble rather than a repeat.
  always_comb begin
    hold     = 1'b1;
    IF_flush = 1'b1;
    if (rst || branch_taken) begin
      hold     = 1'b1;
      IF_flush = 1'b1;
    end else if (stall_in) begin
      hold     = 1'b1;
      IF_flush = 1'b0;
    end else if (buf_valid_q) begin
      hold     = 1'b0;
      IF_flush = 1'b0;
    end
  end

  assign consume = ~hold;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      IDLE:    imem_req = (~buf_valid_q | consume) & ~branch_taken;
      WAIT:    imem_req = 1'b1;
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
    if (rst) begin
      imem_req = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_valid_d   = buf_valid_q;
    buf_instr_d   = buf_instr_q;
    buf_pcplus4_d = buf_pcplus4_q;
    drain_addr_d  = drain_addr_q;

    if (consume) begin
      buf_valid_d = 1'b0;
    end

    if (branch_taken) begin
      // A redirect beats both a stall and any response arriving this cycle.
      buf_valid_d = 1'b0;
      pc_d        = redirect_pc;
      case (state_q)
        IDLE:  state_d = IDLE;
        WAIT: begin
          if (imem_ready) begin
            state_d = IDLE;
          end else begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (imem_req) begin
            if (imem_ready) begin
              buf_instr_d   = imem_rdata;
              buf_pcplus4_d = pc_plus4;
              buf_valid_d   = 1'b1;
              pc_d          = pc_plus4;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_ready) begin
            buf_instr_d   = imem_rdata;
            buf_pcplus4_d = pc_plus4;
            buf_valid_d   = 1'b1;
            pc_d          = pc_plus4;
            state_d       = IDLE;
          end
        end
        DRAIN: begin
          // The stale response is dropped; the buffer stays empty.
          if (imem_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      buf_valid_q   <= 1'b0;
      buf_instr_q   <= 32'h0;
      buf_pcplus4_q <= 32'h0;
      drain_addr_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_valid_q   <= buf_valid_d;
      buf_instr_q   <= buf_instr_d;
      buf_pcplus4_q <= buf_pcplus4_d;
      drain_addr_q  <= drain_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model compared every cycle, plus pinned
// literal expectations; a second instance starts at the top of the address space.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, ready = 1'b0, stall = 1'b0, br = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        req, hold, flush;
  logic [31:0] addr, rdata, instr, pc4;

  logic        req2, hold2, flush2;
  logic [31:0] addr2, rdata2, instr2, pc42;
  logic        one = 1'b1, zero = 1'b0;
  logic [31:0] zero32 = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hC0DE_0000 | (a & 32'h0000_FFFF);
  endfunction

  assign rdata  = ready ? memf(addr) : 32'hDEAD_BEEF;
  assign rdata2 = memf(addr2);

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_ready(ready),
    .imem_rdata(rdata), .stall_in(stall), .branch_taken(br), .branch_target(tgt),
    .instrOut(instr), .PCplus4(pc4), .hold(hold), .IF_flush(flush)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2), .imem_ready(one),
    .imem_rdata(rdata2), .stall_in(zero), .branch_taken(zero), .branch_target(zero32),
    .instrOut(instr2), .PCplus4(pc42), .hold(hold2), .IF_flush(flush2)
  );

  int n_tests = 0, n_fail = 0;
  bit mon_en = 1'b0;

  localparam int P_REQ = 0, P_ADDR = 1, P_HOLD = 2, P_FLUSH = 3, P_INSTR = 4, P_PC4 = 5;
  localparam int P2_REQ = 6, P2_ADDR = 7, P2_INSTR = 8, P2_PC4 = 9, P2_HOLD = 10, P2_FLUSH = 11;
  localparam int NPIN = 12;
  bit          pin_en [NPIN];
  logic [31:0] pin_v  [NPIN];
  string pin_name [NPIN] = '{"pin_req", "pin_addr", "pin_hold", "pin_flush", "pin_instr",
                             "pin_pc4", "pin2_req", "pin2_addr", "pin2_instr", "pin2_pc4",
                             "pin2_hold", "pin2_flush"};

  function automatic logic [31:0] pin_act(input int k);
    case (k)
      P_REQ:    return 32'(req);
      P_ADDR:   return addr;
      P_HOLD:   return 32'(hold);
      P_FLUSH:  return 32'(flush);
      P_INSTR:  return instr;
      P_PC4:    return pc4;
      P2_REQ:   return 32'(req2);
      P2_ADDR:  return addr2;
      P2_INSTR: return instr2;
      P2_PC4:   return pc42;
      P2_HOLD:  return 32'(hold2);
      default:  return 32'(flush2);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model state: fetch PC, buffered instruction, and the single in-flight request.
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0, m_out_a = 32'h0;
  bit          m_full = 1'b0, m_out_v = 1'b0, m_out_d = 1'b0;

  initial begin
    logic        e_req, e_hold, e_flush, cur_d;
    logic [31:0] e_addr;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst || br)   {e_hold, e_flush} = 2'b11;
        else if (stall)  {e_hold, e_flush} = 2'b10;
        else if (m_full) {e_hold, e_flush} = 2'b00;
        else             {e_hold, e_flush} = 2'b11;
        e_addr = m_pc;
        if (rst) e_req = 1'b0;
        else if (m_out_v) begin
          e_req  = 1'b1;
          e_addr = m_out_a;
        end else if (br) e_req = 1'b0;
        else e_req = !m_full || !e_hold;

        chk("imem_req", 32'(req), 32'(e_req));
        if (e_req) chk("imem_addr", addr, e_addr);
        chk("hold", 32'(hold), 32'(e_hold));
        chk("IF_flush", 32'(flush), 32'(e_flush));
        chk("instrOut", instr, m_instr);
        chk("PCplus4", pc4, m_pc4);
        for (int k = 0; k < NPIN; k++) begin
          if (pin_en[k]) chk(pin_name[k], pin_act(k), pin_v[k]);
        end

        if (rst) begin
          m_pc = 32'h0; m_full = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_out_v = 1'b0;
        end else begin
          cur_d = m_out_v ? m_out_d : 1'b0;
          if (br) begin
            m_full = 1'b0;
            m_pc   = tgt & 32'hFFFF_FFFC;
            if (e_req && !ready) begin
              m_out_v = 1'b1; m_out_a = e_addr; m_out_d = 1'b1;
            end else m_out_v = 1'b0;
          end else begin
            if (!e_hold) m_full = 1'b0;
            if (e_req && ready) begin
              m_out_v = 1'b0;
              if (!cur_d) begin
                m_instr = memf(e_addr);
                m_pc4   = e_addr + 32'd4;
                m_pc    = e_addr + 32'd4;
                m_full  = 1'b1;
              end
            end else if (e_req) begin
              m_out_v = 1'b1; m_out_a = e_addr; m_out_d = cur_d;
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic r, input logic rd, input logic s, input logic b,
                       input logic [31:0] t);
    @(posedge clk);
    #1;
    rst = r; ready = rd; stall = s; br = b; tgt = t;
    for (int k = 0; k < NPIN; k++) pin_en[k] = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic pin(input int k, input logic [31:0] v);
    pin_en[k] = 1'b1;
    pin_v[k]  = v;
  endtask

  initial begin
    // Reset, with other inputs active to show they are ignored.
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 32'h55);
    pin(P_REQ, 0); pin(P_HOLD, 1); pin(P_FLUSH, 1);
    drive(1, 1, 0, 0, 0);
    pin(P_INSTR, 0); pin(P_PC4, 0); pin(P_REQ, 0);

    // Zero-wait streaming.
    drive(0, 1, 0, 0, 0);
    pin(P_REQ, 1); pin(P_ADDR, 0); pin(P_HOLD, 1); pin(P_FLUSH, 1);
    pin(P2_REQ, 1); pin(P2_ADDR, 32'hFFFF_FFFC); pin(P2_FLUSH, 1);
    drive(0, 1, 0, 0, 0);
    pin(P_ADDR, 4); pin(P_HOLD, 0); pin(P_INSTR, 32'hC0DE_0000); pin(P_PC4, 4);
    pin(P2_ADDR, 0); pin(P2_PC4, 0); pin(P2_INSTR, 32'hC0DE_FFFC); pin(P2_HOLD, 0);
    drive(0, 1, 0, 0, 0);
    pin(P_ADDR, 8); pin(P_PC4, 8); pin(P_INSTR, 32'hC0DE_0004);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    pin(P_ADDR, 32'h14);

    // Load-use stall with a full buffer.
    drive(0, 1, 1, 0, 0);
    pin(P_HOLD, 1); pin(P_FLUSH, 0); pin(P_REQ, 0); pin(P_INSTR, 32'hC0DE_0014);
    drive(0, 1, 1, 0, 0);
    pin(P_REQ, 0); pin(P_INSTR, 32'hC0DE_0014);
    drive(0, 1, 0, 0, 0);
    pin(P_HOLD, 0); pin(P_ADDR, 32'h18); pin(P_INSTR, 32'hC0DE_0014);

    // Response delayed three cycles.
    drive(0, 0, 0, 0, 0);
    pin(P_ADDR, 32'h1C); pin(P_HOLD, 0); pin(P_INSTR, 32'hC0DE_0018);
    drive(0, 0, 0, 0, 0);
    pin(P_ADDR, 32'h1C); pin(P_HOLD, 1); pin(P_FLUSH, 1);
    drive(0, 0, 0, 0, 0);
    pin(P_ADDR, 32'h1C); pin(P_REQ, 1);
    drive(0, 1, 0, 0, 0);
    pin(P_ADDR, 32'h1C); pin(P_HOLD, 1); pin(P_FLUSH, 1);
    drive(0, 1, 0, 0, 0);
    pin(P_HOLD, 0); pin(P_INSTR, 32'hC0DE_001C); pin(P_PC4, 32'h20); pin(P_ADDR, 32'h20);

    // Branch while waiting: drain old address, then fetch the aligned target.
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h0000_0103);
    pin(P_ADDR, 32'h24); pin(P_HOLD, 1); pin(P_FLUSH, 1);
    drive(0, 0, 0, 0, 0);
    pin(P_ADDR, 32'h24); pin(P_REQ, 1);
    drive(0, 1, 0, 0, 0);
    pin(P_ADDR, 32'h24);
    drive(0, 1, 0, 0, 0);
    pin(P_ADDR, 32'h100); pin(P_HOLD, 1); pin(P_FLUSH, 1);
    drive(0, 1, 0, 0, 0);
    pin(P_HOLD, 0); pin(P_INSTR, 32'hC0DE_0100); pin(P_PC4, 32'h104);

    // Branch together with stall on a full buffer.
    drive(0, 1, 1, 1, 32'h200);
    pin(P_HOLD, 1); pin(P_FLUSH, 1); pin(P_REQ, 0);
    drive(0, 1, 0, 0, 0);
    pin(P_REQ, 1); pin(P_ADDR, 32'h200); pin(P_HOLD, 1); pin(P_FLUSH, 1);

    // Second branch while draining overrides the first.
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h300);
    drive(0, 0, 0, 1, 32'h400);
    pin(P_ADDR, 32'h204);
    drive(0, 1, 0, 0, 0);
    pin(P_ADDR, 32'h204);
    drive(0, 1, 0, 0, 0);
    pin(P_ADDR, 32'h400);

    // Reset abandons an outstanding request.
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    pin(P_REQ, 0); pin(P_HOLD, 1); pin(P_FLUSH, 1);
    drive(0, 1, 0, 0, 0);
    pin(P_REQ, 1); pin(P_ADDR, 0);
    drive(0, 1, 0, 0, 0);
    pin(P_INSTR, 32'hC0DE_0000); pin(P_PC4, 4);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 48; i++) begin
      drive(0, (i % 3) != 0, (i % 7) == 3, (i % 11) == 5,
            32'h1000 + 32'(i) * 32'h10 + 32'h3);
    end
    drive(0, 1, 0, 0, 0);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
